// File: rtl/instruction_fetch.sv
// Instruction fetch unit: issues sequential fetch requests, tags each with its PC,
// and buffers in-order responses in a small queue toward the decoder.
module instruction_fetch #(
    parameter int INSTR_WIDTH = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int QUEUE_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [ADDR_WIDTH-1:0]  imem_req_addr,
    input  logic                   imem_resp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_resp_data,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic [ADDR_WIDTH-1:0]  instr_pc
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_WIDTH-1:0] PC_STEP   = ADDR_WIDTH'(INSTR_WIDTH / 8);
    localparam logic [CNT_W:0]        DEPTH_EXT = (CNT_W + 1)'(QUEUE_DEPTH);

    logic [ADDR_WIDTH-1:0]  fetch_pc;
    logic [INSTR_WIDTH-1:0] instr_mem [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0]  pc_mem    [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0]  tag_mem   [QUEUE_DEPTH];

    logic [PTR_W-1:0] q_rd_ptr;
    logic [PTR_W-1:0] q_wr_ptr;
    logic [PTR_W-1:0] tag_rd_ptr;
    logic [PTR_W-1:0] tag_wr_ptr;
    logic [CNT_W-1:0] q_count;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] discard;
    logic [CNT_W:0]   occupancy;

    logic req_fire;
    logic resp_take;
    logic push;
    logic pop;

    // Queued plus in-flight entries never exceed the depth, so every response has a slot.
    assign occupancy      = {1'b0, q_count} + {1'b0, outstanding};
    assign imem_req_valid = rst_n && !redirect_valid && (occupancy < DEPTH_EXT);
    assign imem_req_addr  = fetch_pc;

    assign req_fire  = imem_req_valid && imem_req_ready;
    assign resp_take = imem_resp_valid && (outstanding != '0);
    assign push      = resp_take && (discard == '0) && !redirect_valid;
    assign pop       = instr_valid && instr_ready;

    assign instr_valid = (q_count != '0);
    assign instr_out   = instr_valid ? instr_mem[q_rd_ptr] : '0;
    assign instr_pc    = instr_valid ? pc_mem[q_rd_ptr]    : '0;

    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_mem[tag_wr_ptr] <= fetch_pc;
        end
        if (push) begin
            instr_mem[q_wr_ptr] <= imem_resp_data;
            pc_mem[q_wr_ptr]    <= tag_mem[tag_rd_ptr];
        end
    end

    // Tag pointers follow every response, dropped or kept, so tags stay aligned after redirects.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            q_rd_ptr    <= '0;
            q_wr_ptr    <= '0;
            tag_rd_ptr  <= '0;
            tag_wr_ptr  <= '0;
            q_count     <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(resp_take);
            if (req_fire) begin
                tag_wr_ptr <= tag_wr_ptr + PTR_W'(1);
            end
            if (resp_take) begin
                tag_rd_ptr <= tag_rd_ptr + PTR_W'(1);
            end
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                discard  <= outstanding - CNT_W'(resp_take);
                q_count  <= '0;
                q_rd_ptr <= q_wr_ptr;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + PC_STEP;
                end
                if (resp_take && (discard != '0)) begin
                    discard <= discard - CNT_W'(1);
                end
                if (push) begin
                    q_wr_ptr <= q_wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    q_rd_ptr <= q_rd_ptr + PTR_W'(1);
                end
                q_count <= q_count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a behavioural in-order memory with variable latency
// feeds the DUT while a scoreboard predicts the instruction stream toward the decoder.
module tb_instruction_fetch;

    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;

    instruction_fetch #(
        .INSTR_WIDTH(32),
        .ADDR_WIDTH (32),
        .QUEUE_DEPTH(4),
        .RESET_PC   (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          due;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    pend_t       mem_q[$];
    exp_t        exp_q[$];
    logic [31:0] model_pc;
    int          cycle;
    int          last_due;
    int          lat_min;
    int          lat_max;
    int          vectors;
    int          miscompares;

    logic        s_fire;
    logic        s_pop;
    logic        s_req_valid;
    logic [31:0] s_addr;
    logic        s_instr_valid;
    logic [31:0] s_instr_out;
    logic [31:0] s_instr_pc;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cycle);
        end
    endtask

    // One clock cycle: memory drives its response, outputs are sampled mid-cycle,
    // the scoreboard is updated, then the edge is taken.
    task automatic applyStimulus();
        logic  resp_sent;
        exp_t  e;
        pend_t p;
        int    lat;
        resp_sent = 1'b0;
        if (mem_q.size() > 0 && mem_q[0].due <= cycle) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_q[0].data;
            resp_sent       = 1'b1;
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end
        #1;
        s_req_valid   = imem_req_valid;
        s_addr        = imem_req_addr;
        s_instr_valid = instr_valid;
        s_instr_out   = instr_out;
        s_instr_pc    = instr_pc;
        s_fire        = imem_req_valid && imem_req_ready;
        s_pop         = instr_valid && instr_ready;
        if (!rst_n) begin
            mem_q.delete();
            exp_q.delete();
            model_pc = RESET_PC;
            s_fire   = 1'b0;
            s_pop    = 1'b0;
        end else begin
            if (resp_sent) begin
                void'(mem_q.pop_front());
            end
            if (s_pop) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_instr", s_instr_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("instr_pc", s_instr_pc, e.pc);
                    checkOutput("instr_out", s_instr_out, e.data);
                end
            end
            if (s_fire) begin
                checkOutput("req_addr", s_addr, model_pc);
                lat   = $urandom_range(lat_max, lat_min);
                p.due = (cycle + lat > last_due + 1) ? cycle + lat : last_due + 1;
                p.data = mem_data(s_addr);
                last_due = p.due;
                mem_q.push_back(p);
                e.pc   = model_pc;
                e.data = mem_data(model_pc);
                exp_q.push_back(e);
                model_pc = model_pc + 32'd4;
            end
            if (redirect_valid) begin
                checkOutput("req_valid_in_redirect", s_req_valid, 1'b0);
                exp_q.delete();
                model_pc = redirect_pc;
            end
        end
        @(posedge clk);
        cycle++;
        @(negedge clk);
    endtask

    task automatic applyReset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        applyStimulus();
        applyStimulus();
        checkOutput("rst_req_valid", imem_req_valid, 1'b0);
        checkOutput("rst_instr_valid", instr_valid, 1'b0);
        checkOutput("rst_instr_out", instr_out, 32'h0);
        checkOutput("rst_instr_pc", instr_pc, 32'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        int first_fire;
        int first_valid;
        int fires;
        int pops;
        logic [31:0] first_pop_pc;
        logic        seen_pop;
        logic [31:0] fire_addrs[$];

        vectors        = 0;
        miscompares    = 0;
        cycle          = 0;
        last_due       = 0;
        lat_min        = 1;
        lat_max        = 1;
        model_pc       = RESET_PC;
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;
        @(negedge clk);

        // Streaming with single-cycle memory and an always-ready decoder.
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        applyReset();
        first_fire  = 0;
        first_valid = 0;
        fires       = 0;
        for (int k = 1; k <= 8; k++) begin
            applyStimulus();
            if (s_fire) fires++;
            if (s_fire && first_fire == 0) first_fire = k;
            if (s_instr_valid && first_valid == 0) first_valid = k;
        end
        checkOutput("first_fire_cycle", first_fire, 1);
        checkOutput("first_valid_cycle", first_valid, 3);
        checkOutput("stream_fires", fires, 8);

        // Decoder stalls: the queue fills and fetch stops at four requests.
        instr_ready = 1'b0;
        applyReset();
        fires = 0;
        for (int k = 1; k <= 10; k++) begin
            applyStimulus();
            if (s_fire) fires++;
            if (s_instr_valid) begin
                checkOutput("held_instr_out", s_instr_out, mem_data(32'h0));
                checkOutput("held_instr_pc", s_instr_pc, 32'h0);
            end
        end
        checkOutput("stall_fires", fires, 4);
        checkOutput("stall_req_valid", s_req_valid, 1'b0);
        checkOutput("stall_instr_valid", s_instr_valid, 1'b1);
        instr_ready = 1'b1;
        pops = 0;
        for (int k = 0; k < 20; k++) begin
            applyStimulus();
            if (s_pop) pops++;
        end
        checkOutput("drain_progress", pops > 4, 1'b1);

        // Redirect with two responses in flight and two instructions queued.
        instr_ready = 1'b0;
        lat_min     = 3;
        lat_max     = 3;
        applyReset();
        for (int k = 0; k < 5; k++) applyStimulus();
        checkOutput("pre_redirect_valid", instr_valid, 1'b1);
        checkOutput("pre_redirect_full", imem_req_valid, 1'b0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        applyStimulus();
        redirect_valid = 1'b0;
        lat_min        = 1;
        lat_max        = 1;
        applyStimulus();
        checkOutput("post_redirect_instr_valid", s_instr_valid, 1'b0);
        checkOutput("post_redirect_req_valid", s_req_valid, 1'b1);
        checkOutput("post_redirect_addr", s_addr, 32'h100);
        instr_ready = 1'b1;
        seen_pop    = 1'b0;
        first_pop_pc = 32'h0;
        for (int k = 0; k < 15; k++) begin
            applyStimulus();
            if (s_pop && !seen_pop) begin
                seen_pop     = 1'b1;
                first_pop_pc = s_instr_pc;
            end
        end
        checkOutput("redirect_first_pop_seen", seen_pop, 1'b1);
        checkOutput("redirect_first_pc", first_pop_pc, 32'h100);

        // Random backpressure, latency and occasional redirects.
        lat_min = 1;
        lat_max = 3;
        for (int k = 0; k < 400; k++) begin
            imem_req_ready = ($urandom_range(3, 0) != 0);
            instr_ready    = ($urandom_range(3, 0) != 0);
            redirect_valid = ($urandom_range(39, 0) == 0);
            redirect_pc    = {$urandom_range(32'hFFFF, 0), 16'h0} | {16'h0, 16'($urandom_range(255, 0) * 4)};
            applyStimulus();
        end
        redirect_valid = 1'b0;

        // PC wraps from the top of the address space to zero.
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        lat_min        = 1;
        lat_max        = 1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        applyStimulus();
        redirect_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            applyStimulus();
            if (s_fire) fire_addrs.push_back(s_addr);
        end
        checkOutput("wrap_fire_count", fire_addrs.size() >= 4, 1'b1);
        if (fire_addrs.size() >= 4) begin
            checkOutput("wrap_addr0", fire_addrs[0], 32'hFFFF_FFF8);
            checkOutput("wrap_addr1", fire_addrs[1], 32'hFFFF_FFFC);
            checkOutput("wrap_addr2", fire_addrs[2], 32'h0000_0000);
            checkOutput("wrap_addr3", fire_addrs[3], 32'h0000_0004);
        end

        // Reset while three instructions are queued.
        instr_ready = 1'b0;
        applyReset();
        for (int k = 0; k < 4; k++) applyStimulus();
        checkOutput("pre_reset_valid", instr_valid, 1'b1);
        rst_n = 1'b0;
        applyStimulus();
        checkOutput("mid_reset_instr_valid", instr_valid, 1'b0);
        checkOutput("mid_reset_instr_out", instr_out, 32'h0);
        rst_n = 1'b1;
        #1;
        checkOutput("after_reset_req_valid", imem_req_valid, 1'b1);
        checkOutput("after_reset_req_addr", imem_req_addr, RESET_PC);
        instr_ready = 1'b1;
        for (int k = 0; k < 10; k++) applyStimulus();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter INSTR_WIDTH, default 32, instruction word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 SHALL have parameter QUEUE_DEPTH, default 4, instruction queue entries (power of two, >=2).
REQ-004 SHALL have parameter RESET_PC, default 0, first fetch address.
REQ-005 SHALL provide one clock; reset is synchronous and active-low: clk input 1, rising-edge clock; rst_n input 1, synchronous active-low reset.
REQ-006 SHALL provide imem_req_valid output 1, fetch request valid.
REQ-007 SHALL provide imem_req_ready input 1, memory accepts request.
REQ-008 SHALL provide imem_req_addr output ADDR_WIDTH, fetch byte address.
REQ-009 SHALL provide imem_resp_valid input 1, response data valid, in request order, latency >=1 cycle.
REQ-010 SHALL provide imem_resp_data input INSTR_WIDTH, fetched instruction.
REQ-011 SHALL provide redirect_valid input 1, branch/jump redirect pulse.
REQ-012 SHALL provide redirect_pc input ADDR_WIDTH, redirect target.
REQ-013 SHALL provide instr_valid output 1, instr_out valid toward decoder.
REQ-014 SHALL provide instr_ready input 1, decoder accepts instruction.
REQ-015 SHALL provide instr_out output INSTR_WIDTH, instruction to decoder (feeds instruction_decoder instr_in).
REQ-016 SHALL provide instr_pc output ADDR_WIDTH, address of instr_out.

Function
REQ-017 SHALL hold fetch PC register; request handshake = imem_req_valid && imem_req_ready; each handshake advances PC by INSTR_WIDTH/8, wrapping modulo 2^ADDR_WIDTH.
REQ-018 SHALL drive imem_req_addr = fetch PC combinationally; request SHALL stay stable while valid and not ready.
REQ-019 SHALL assert imem_req_valid only when queue_count + outstanding < QUEUE_DEPTH and redirect_valid is low, guaranteeing every response a queue slot.
REQ-020 SHALL track outstanding (accepted, unanswered) requests in a counter of width clog2(QUEUE_DEPTH)+1; same-cycle handshake and response leave it unchanged.
REQ-021 SHALL tag each request with its PC in a PC FIFO so instr_pc matches instr_out.
REQ-022 SHALL write each non-discarded response into the queue the cycle imem_resp_valid is high; no bypass, minimum request-to-instr_valid latency = memory latency + 1.
REQ-023 SHALL present queue head on instr_out/instr_pc with instr_valid = queue non-empty; pop on instr_valid && instr_ready; simultaneous push and pop legal, count unchanged.
REQ-024 SHALL hold instr_out/instr_pc stable while instr_valid high and instr_ready low.
REQ-025 On redirect_valid, SHALL in that cycle flush queue (count 0, instr_valid low next cycle), load PC = redirect_pc, and set discard counter = outstanding after this cycle's response decrement.
REQ-026 SHALL drop responses while discard counter non-zero, decrementing it per response; fetch from redirect_pc SHALL begin the cycle after redirect.
REQ-027 A pop coinciding with redirect SHALL complete (decoder sees the handshake); push coinciding with redirect SHALL be discarded.
REQ-028 Back-to-back redirects SHALL each take effect; last one defines PC.
REQ-029 SHALL never overflow queue nor underflow it; imem_resp_valid with zero outstanding is illegal and SHALL be ignored.

Reset
REQ-030 While rst_n low at clk edge: PC = RESET_PC, queue count 0, outstanding 0, discard 0, imem_req_valid 0, instr_valid 0, instr_out 0, instr_pc 0.
REQ-031 Reset mid-operation SHALL drop all in-flight state; responses arriving after reset for pre-reset requests are the memory's responsibility to suppress.
REQ-032 First request SHALL be issued the first cycle after rst_n high.

Verification
REQ-033 Reset, memory ready, 1-cycle latency, instr_ready=1 -> addrs 0x0,0x4,0x8... issued every cycle; instr_valid from cycle 3 with matching instr_pc.
REQ-034 instr_ready=0 for 10 cycles -> exactly 4 requests issued, queue full, imem_req_valid low; instr_out stable; release -> in-order drain, no loss.
REQ-035 Redirect to 0x100 with 2 outstanding and 2 queued -> both responses dropped, queue empty, next request 0x100, first instr_pc 0x100.
REQ-036 imem_req_ready toggled randomly, latency 1-3 -> instr_pc sequence strictly +4, no duplicates/skips.
REQ-037 PC 0xFFFFFFFC fetched -> next request 0x00000000.
REQ-038 rst_n low while 3 queued -> next cycle instr_valid 0, imem_req_addr RESET_PC after release.
